// File: rtl/rgmii_rx_frame_gen.sv
// RGMII receive-side frame generator: replays stored frames as rxd/rx_ctl nibble streams.
// Define RGMII_FRAME_GEN_FCS_EN to append a generated CRC-32 FCS after each payload.

module rgmii_rx_frame_gen #(
    parameter int  FRAME_NUM       = 4,
    parameter int  MAX_LEN         = 128,
    parameter int  START_DELAY     = 32,
    parameter int  IFG_BYTES       = 12,
    parameter int  INSERT_PREAMBLE = 1,
    localparam int IDX_W           = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1,
    localparam int ADDR_W          = $clog2(MAX_LEN),
    localparam int LEN_W           = ADDR_W + 1,
    localparam int FCNT_W          = IDX_W + 1
) (
    input  logic              sys_clk_in,
    input  logic              sys_rstn_in,
    input  logic              wr_en_in,
    input  logic [IDX_W-1:0]  wr_frame_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [7:0]        wr_data_in,
    input  logic              len_wr_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [FCNT_W-1:0] frame_cnt_in,
    input  logic              loop_in,
    input  logic              start_in,
    input  logic              stop_in,
    output logic [3:0]        rgmii_rxd_out,
    output logic              rgmii_rx_ctl_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [IDX_W-1:0]  frame_idx_out
);

    localparam int DELAY_CYC = 2 * START_DELAY;
    localparam int GAP_CYC   = 2 * IFG_BYTES;
    localparam int DATA_MAX  = 2 * MAX_LEN;
    localparam int CNT_MAX_A = (DELAY_CYC > GAP_CYC) ? DELAY_CYC : GAP_CYC;
    localparam int CNT_MAX_B = (DATA_MAX > 16) ? DATA_MAX : 16;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int MEM_DEPTH = 1 << (IDX_W + ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_PRE   = 3'd2,
        S_DATA  = 3'd3,
`ifdef RGMII_FRAME_GEN_FCS_EN
        S_FCS   = 3'd6,
`endif
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_r;
    state_t              nxt_state_s;
    state_t              first_state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    nxt_cnt_s;
    logic [CNT_W-1:0]    data_last_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    nxt_idx_s;
    logic [FCNT_W-1:0]   fcnt_r;
    logic                stop_pend_r;
    logic                stop_now_s;
    logic                busy_s;
    logic [LEN_W-1:0]    len_tab_r [FRAME_NUM];
    logic [7:0]          mem_r [MEM_DEPTH];
    logic [7:0]          rd_data_r;
    logic [FRAME_NUM-1:0] slot_live_s;
    logic [FCNT_W-1:0]   search_base_s;
    logic                fwd_ok_s;
    logic [IDX_W-1:0]    fwd_idx_s;
    logic                wrap_ok_s;
    logic [IDX_W-1:0]    wrap_idx_s;
    logic                go_ok_s;
    logic [IDX_W-1:0]    go_idx_s;
    logic [3:0]          nib_s;
    logic                ctl_s;
    logic [3:0]          rxd_r;
    logic                ctl_r;
    logic                busy_r;
    logic                done_r;
    logic [IDX_W-1:0]    idx_out_r;
`ifdef RGMII_FRAME_GEN_FCS_EN
    logic [31:0]         crc_r;
    logic [31:0]         fcs_s;
`endif

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

    function automatic logic [FCNT_W-1:0] clamp_fcnt(input logic [FCNT_W-1:0] n);
        if (n == {FCNT_W{1'b0}}) begin
            return FCNT_W'(1);
        end else if (n > FCNT_W'(FRAME_NUM)) begin
            return FCNT_W'(FRAME_NUM);
        end else begin
            return n;
        end
    endfunction

`ifdef RGMII_FRAME_GEN_FCS_EN
    // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction
`endif

    assign busy_s        = (state_r != S_IDLE);
    assign stop_now_s    = stop_in | stop_pend_r;
    assign first_state_s = (INSERT_PREAMBLE != 0) ? S_PRE : S_DATA;
    assign data_last_s   = CNT_W'({clamp_len(len_tab_r[idx_r]), 1'b0}) - CNT_W'(1);

    // Length table: cleared by reset, frozen while a replay is running
    always_ff @(posedge sys_clk_in or negedge sys_rstn_in) begin
        if (!sys_rstn_in) begin
            for (int i = 0; i < FRAME_NUM; i++) begin
                len_tab_r[i] <= {LEN_W{1'b0}};
            end
        end else if (len_wr_in && !busy_s) begin
            len_tab_r[wr_frame_in] <= len_in;
        end
    end

    // Frame RAM; the read address follows the next state so data is ready on entry
    always_ff @(posedge sys_clk_in) begin
        if (wr_en_in && !busy_s) begin
            mem_r[{wr_frame_in, wr_addr_in}] <= wr_data_in;
        end
        rd_data_r <= mem_r[{nxt_idx_s, nxt_cnt_s[ADDR_W:1]}];
    end

    // Slots that belong to this pass and carry a payload
    always_comb begin
        for (int j = 0; j < FRAME_NUM; j++) begin
            slot_live_s[j] = (clamp_len(len_tab_r[j]) != {LEN_W{1'b0}}) && (FCNT_W'(j) < fcnt_r);
        end
    end

    // Next slot to send: first live slot at or after the search base, else wrap when looping
    always_comb begin
        search_base_s = (state_r == S_DELAY) ? {FCNT_W{1'b0}} : ({1'b0, idx_r} + FCNT_W'(1));
        fwd_ok_s      = 1'b0;
        fwd_idx_s     = {IDX_W{1'b0}};
        wrap_ok_s     = 1'b0;
        wrap_idx_s    = {IDX_W{1'b0}};
        for (int j = FRAME_NUM - 1; j >= 0; j--) begin
            fwd_ok_s   = fwd_ok_s | (slot_live_s[j] && (FCNT_W'(j) >= search_base_s));
            fwd_idx_s  = (slot_live_s[j] && (FCNT_W'(j) >= search_base_s)) ? IDX_W'(j) : fwd_idx_s;
            wrap_ok_s  = wrap_ok_s | slot_live_s[j];
            wrap_idx_s = slot_live_s[j] ? IDX_W'(j) : wrap_idx_s;
        end
        go_ok_s  = fwd_ok_s | (loop_in & wrap_ok_s);
        go_idx_s = fwd_ok_s ? fwd_idx_s : wrap_idx_s;
    end

    // FSM state register, phase counter, slot index and run configuration
    always_ff @(posedge sys_clk_in or negedge sys_rstn_in) begin
        if (!sys_rstn_in) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            fcnt_r      <= FCNT_W'(1);
            stop_pend_r <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            cnt_r   <= nxt_cnt_s;
            idx_r   <= nxt_idx_s;
            if (state_r == S_IDLE) begin
                stop_pend_r <= 1'b0;
                if (start_in) begin
                    fcnt_r <= clamp_fcnt(frame_cnt_in);
                end
            end else begin
                stop_pend_r <= stop_pend_r | stop_in;
            end
        end
    end

    // FSM next-state logic
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r + CNT_W'(1);
        nxt_idx_s   = idx_r;
        case (state_r)
            S_IDLE: begin
                nxt_cnt_s = {CNT_W{1'b0}};
                if (start_in) begin
                    nxt_state_s = S_DELAY;
                    nxt_idx_s   = {IDX_W{1'b0}};
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_DELAY, S_GAP: begin
                if ((state_r == S_DELAY) && stop_now_s) begin
                    nxt_state_s = S_DONE;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == ((state_r == S_DELAY) ? CNT_W'(DELAY_CYC - 1) : CNT_W'(GAP_CYC - 1))) begin
                    nxt_cnt_s = {CNT_W{1'b0}};
                    if (go_ok_s && !stop_now_s) begin
                        nxt_state_s = first_state_s;
                        nxt_idx_s   = go_idx_s;
                    end else begin
                        nxt_state_s = S_DONE;
                    end
                end else begin
                    nxt_state_s = state_r;
                end
            end
            S_PRE: begin
                if (cnt_r == CNT_W'(15)) begin
                    nxt_state_s = S_DATA;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    nxt_state_s = S_PRE;
                end
            end
            S_DATA: begin
                if (cnt_r == data_last_s) begin
`ifdef RGMII_FRAME_GEN_FCS_EN
                    nxt_state_s = S_FCS;
`else
                    nxt_state_s = S_GAP;
`endif
                    nxt_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    nxt_state_s = S_DATA;
                end
            end
`ifdef RGMII_FRAME_GEN_FCS_EN
            S_FCS: begin
                if (cnt_r == CNT_W'(7)) begin
                    nxt_state_s = S_GAP;
                    nxt_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    nxt_state_s = S_FCS;
                end
            end
`endif
            S_DONE: begin
                nxt_state_s = S_IDLE;
                nxt_cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                nxt_state_s = S_IDLE;
                nxt_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

`ifdef RGMII_FRAME_GEN_FCS_EN
    // Running CRC over payload bytes, seeded before every frame
    always_ff @(posedge sys_clk_in or negedge sys_rstn_in) begin
        if (!sys_rstn_in) begin
            crc_r <= 32'hFFFFFFFF;
        end else if (state_r == S_DATA) begin
            if (cnt_r[0]) begin
                crc_r <= crc32_byte(crc_r, rd_data_r);
            end
        end else if (state_r != S_FCS) begin
            crc_r <= 32'hFFFFFFFF;
        end
    end

    assign fcs_s = ~crc_r;
`endif

    // FSM output decode: nibble and data-valid for the current phase
    always_comb begin
        nib_s = 4'h0;
        ctl_s = 1'b0;
        case (state_r)
            S_PRE: begin
                ctl_s = 1'b1;
                nib_s = (cnt_r == CNT_W'(15)) ? 4'hD : 4'h5;
            end
            S_DATA: begin
                ctl_s = 1'b1;
                nib_s = cnt_r[0] ? rd_data_r[7:4] : rd_data_r[3:0];
            end
`ifdef RGMII_FRAME_GEN_FCS_EN
            S_FCS: begin
                ctl_s = 1'b1;
                nib_s = fcs_s[{cnt_r[2:0], 2'b00} +: 4];
            end
`endif
            default: begin
                ctl_s = 1'b0;
                nib_s = 4'h0;
            end
        endcase
    end

    // Registered outputs; busy/done follow the next state so busy rises the cycle after start
    always_ff @(posedge sys_clk_in or negedge sys_rstn_in) begin
        if (!sys_rstn_in) begin
            rxd_r     <= 4'h0;
            ctl_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            idx_out_r <= {IDX_W{1'b0}};
        end else begin
            rxd_r     <= nib_s;
            ctl_r     <= ctl_s;
            busy_r    <= (nxt_state_s != S_IDLE) && (nxt_state_s != S_DONE);
            done_r    <= (nxt_state_s == S_DONE);
            idx_out_r <= idx_r;
        end
    end

    assign rgmii_rxd_out    = rxd_r;
    assign rgmii_rx_ctl_out = ctl_r;
    assign busy_out         = busy_r;
    assign done_out         = done_r;
    assign frame_idx_out    = idx_out_r;

endmodule
